store_buffer: RTL and testbench
===============================

# store_buffer

Memory-side responder for the pipeline's committed-store interface. Accepts stores presented on the datafifo port, queues them in a DEPTH-entry FIFO, and drains them in order to a data memory write port using a valid/ready handshake. It drives the full signal that back-pressures the commit stage, and optionally converts size/address into byte strobes with lane-shifted data.

## Interface
Parameters:
- DEPTH, 4, number of queued stores; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- datafifo_valid_out  in  1  store push request from commit.
- datafifo_addr_out  in  32  store byte address.
- datafifo_val_out  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- datafifo_size_out  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- datafifo_full  out  1  high when count == DEPTH.
- mem_wr_valid  out  1  head entry is presented to memory.
- mem_wr_ready  in  1  memory accepts the head entry this cycle.
- mem_wr_addr  out  32  write address.
- mem_wr_data  out  32  write data.
- mem_wr_size  out  2  size of the head entry.
- mem_wr_strb  out  4  byte enables. Driven only when STORE_BUFFER_STRB_EN is defined.
- empty  out  1  high when count == 0.
- overflow_err  out  1  sticky flag: a push arrived while full.
- misalign_err  out  1  sticky flag: a misaligned or reserved-size store was discarded. Driven only when STORE_BUFFER_STRB_EN is defined.

## Operation
- Storage: DEPTH entries of {addr, data, size}. Write pointer, read pointer, count register of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push:
  - Occurs when datafifo_valid_out && !datafifo_full.
  - Writes the entry at wptr, then wptr+1 and count+1.
- Push while full:
  - The entry is dropped; no state change.
  - overflow_err is set and stays set until reset.
- Pop:
  - Occurs when mem_wr_valid && mem_wr_ready.
  - rptr+1 and count-1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - At count == DEPTH, datafifo_full is high, so the push is refused even though a pop happens that same cycle.
  - At count == 0 no pop is possible, because mem_wr_valid is low.
- Output: mem_wr_valid = !empty. mem_wr_* show the head entry directly from storage.
- Handshake: while mem_wr_valid is high and mem_wr_ready is low, all mem_wr_* outputs hold stable. No entry is reordered, merged, or lost once accepted.
- Full and empty flags are combinational decodes of the count register, so they are glitch-free relative to clk.
- Reset:
  - While reset is low at a clock edge: pointers, count, and sticky flags clear.
  - Resulting outputs: datafifo_full = 0, empty = 1, mem_wr_valid = 0, overflow_err = 0, misalign_err = 0.
  - mem_wr_addr, mem_wr_data, mem_wr_size and mem_wr_strb read as 0 while empty.
  - Reset mid-operation discards all queued stores, including a head entry currently being handshaken.

## Timing
- Push to visibility: a store pushed at edge N shows mem_wr_valid = 1 after edge N, so it can be accepted in cycle N+1.
- Best-case throughput: one push and one pop per cycle.
- datafifo_full deasserts in the cycle after the pop edge that brings count below DEPTH.
- There is no combinational path from datafifo_valid_out to datafifo_full, or from mem_wr_ready to datafifo_full.
- There is a combinational path from storage to mem_wr_* only. No input-to-output combinational paths.

## Configuration
- Macro STORE_BUFFER_STRB_EN.
- Defined:
  - mem_wr_addr = {addr[31:2], 2'b00}.
  - mem_wr_strb and data lanes by size:
    - Byte: strb = 4'b0001 << addr[1:0], data = {4{val[7:0]}}.
    - Half: strb = 4'b0011 << addr[1:0], data = {2{val[15:0]}}.
    - Word: strb = 4'b1111, data = val.
  - A push is accepted but discarded (not enqueued), and misalign_err is set, if any of:
    - half with addr[0] = 1;
    - word with addr[1:0] != 0;
    - size = 3.
  - Such a push still counts as a handshake for overflow checking.
- Undefined:
  - mem_wr_addr, mem_wr_data and mem_wr_size pass through unmodified.
  - mem_wr_strb is tied to 4'b0000 and misalign_err is tied to 0.
  - Every non-full push is enqueued regardless of alignment or size.

## Test plan
- Single store: after reset, push word addr 0x100 val 0xDEADBEEF with mem_wr_ready = 1 -> mem_wr_valid high for exactly one cycle. With STRB_EN: mem_wr_addr 0x100, strb 4'b1111, data 0xDEADBEEF.
- Fill and backpressure (DEPTH = 4): mem_wr_ready = 0, push 5 stores -> datafifo_full high after the 4th push, 5th push dropped, overflow_err = 1. Then ready = 1 -> 4 stores drained in push order, empty = 1.
- Stall stability: ready toggles 0,0,1 with the head at byte addr 0x203 val 0xAB -> outputs stay constant over the stall, pop occurs on the 3rd cycle. With STRB_EN: strb 4'b1000, data 0xABABABAB.
- Concurrent push/pop at count = 2 for 10 cycles with ready = 1 -> count stays 2, pointers wrap past DEPTH, order preserved.
- Misaligned (STRB_EN): push half at 0x101 -> not enqueued, empty stays 1, misalign_err = 1. Without the macro, the same push is enqueued with mem_wr_addr 0x101 and size 1.
- Reset mid-operation: 3 entries queued and ready = 0, reset held low for 1 edge -> empty = 1, mem_wr_valid = 0, both sticky flags 0, no further memory writes issued.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store FIFO draining to a data memory write port
//
// Optional feature macro: STORE_BUFFER_STRB_EN (byte strobes, lane replication,
// misaligned/reserved-size store discard). Undefined by default.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous active-low reset
//   datafifo_valid_out  store push request from commit
//   datafifo_addr_out   store byte address
//   datafifo_val_out    store data, right-justified
//   datafifo_size_out   0 byte, 1 half, 2 word, 3 reserved
//   datafifo_full       back-pressure to commit (count == DEPTH)
//   mem_wr_valid        head entry presented to memory
//   mem_wr_ready        memory accepts head entry
//   mem_wr_addr/data/size/strb  head entry write fields (zero while empty)
//   empty               count == 0
//   overflow_err        sticky: push arrived while full
//   misalign_err        sticky: misaligned or reserved-size store discarded
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        datafifo_valid_out,
  input  logic [31:0] datafifo_addr_out,
  input  logic [31:0] datafifo_val_out,
  input  logic [1:0]  datafifo_size_out,
  output logic        datafifo_full,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [1:0]  mem_wr_size,
  output logic [3:0]  mem_wr_strb,
  output logic        empty,
  output logic        overflow_err,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [1:0]  size_mem [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic push_hs;
  logic push_ok;
  logic enq;
  logic pop;

  logic [31:0] head_addr;
  logic [31:0] head_data;
  logic [1:0]  head_size;

  assign datafifo_full = (count == FULL_CNT);
  assign empty         = (count == '0);
  assign mem_wr_valid  = !empty;

  // A push handshake happens whenever the FIFO is not full; whether the
  // store is actually enqueued also depends on its alignment.
  assign push_hs = datafifo_valid_out && !datafifo_full;
  assign pop     = mem_wr_valid && mem_wr_ready;

`ifdef STORE_BUFFER_STRB_EN
  assign push_ok = !((datafifo_size_out == 2'd3) ||
                     (datafifo_size_out == 2'd1 && datafifo_addr_out[0]) ||
                     (datafifo_size_out == 2'd2 && datafifo_addr_out[1:0] != 2'b00));
`else
  assign push_ok = 1'b1;
`endif

  assign enq = push_hs && push_ok;

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wptr] <= datafifo_addr_out;
      data_mem[wptr] <= datafifo_val_out;
      size_mem[wptr] <= datafifo_size_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
`ifdef STORE_BUFFER_STRB_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (datafifo_valid_out && datafifo_full) overflow_err <= 1'b1;
`ifdef STORE_BUFFER_STRB_EN
      if (push_hs && !push_ok) misalign_err <= 1'b1;
`endif
    end
  end

  assign head_addr = addr_mem[rptr];
  assign head_data = data_mem[rptr];
  assign head_size = size_mem[rptr];

`ifdef STORE_BUFFER_STRB_EN
  // Entries are stored raw; word alignment, lane replication and strobes
  // are derived from the head entry on the way out.
  always_comb begin
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_size = '0;
    mem_wr_strb = '0;
    if (mem_wr_valid) begin
      mem_wr_addr = {head_addr[31:2], 2'b00};
      mem_wr_size = head_size;
      case (head_size)
        2'd0: begin
          mem_wr_strb = 4'b0001 << head_addr[1:0];
          mem_wr_data = {4{head_data[7:0]}};
        end
        2'd1: begin
          mem_wr_strb = 4'b0011 << head_addr[1:0];
          mem_wr_data = {2{head_data[15:0]}};
        end
        2'd2: begin
          mem_wr_strb = 4'b1111;
          mem_wr_data = head_data;
        end
        default: begin
          mem_wr_strb = 4'b0000;
          mem_wr_data = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_size = '0;
    if (mem_wr_valid) begin
      mem_wr_addr = head_addr;
      mem_wr_data = head_data;
      mem_wr_size = head_size;
    end
  end

  assign mem_wr_strb  = 4'b0000;
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer against a queue model
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        v;
  logic [31:0] a;
  logic [31:0] d;
  logic [1:0]  s;
  logic        rdy;

  logic        full_o, valid_o, empty_o, ovf_o, mis_o;
  logic [31:0] addr_o, data_o;
  logic [1:0]  size_o;
  logic [3:0]  strb_o;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (rstn),
    .datafifo_valid_out (v),
    .datafifo_addr_out  (a),
    .datafifo_val_out   (d),
    .datafifo_size_out  (s),
    .datafifo_full      (full_o),
    .mem_wr_valid       (valid_o),
    .mem_wr_ready       (rdy),
    .mem_wr_addr        (addr_o),
    .mem_wr_data        (data_o),
    .mem_wr_size        (size_o),
    .mem_wr_strb        (strb_o),
    .empty              (empty_o),
    .overflow_err       (ovf_o),
    .misalign_err       (mis_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } ent_t;

  ent_t m_q[$];
  bit   m_ovf;
  bit   m_mis;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   chk_en  = 1'b0;
  int   n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit legal(input logic [31:0] ad, input logic [1:0] sz);
`ifdef STORE_BUFFER_STRB_EN
    if (sz == 2'd3) return 1'b0;
    if (sz == 2'd1 && ad[0]) return 1'b0;
    if (sz == 2'd2 && ad[1:0] != 2'b00) return 1'b0;
    return 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  // Model step at a rising edge, using the inputs held across it.
  task automatic model_edge();
    bit was_full;
    bit do_pop;
    if (!rstn) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      do_pop   = (m_q.size() > 0) && rdy;
      if (do_pop) begin
        void'(m_q.pop_front());
        n_writes++;
      end
      if (v && was_full) m_ovf = 1'b1;
      if (v && !was_full) begin
        if (legal(a, s)) m_q.push_back('{addr: a, data: d, size: s});
        else m_mis = 1'b1;
      end
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] e_addr, e_data;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    if (chk_en) begin
      e_addr = 0; e_data = 0; e_size = 0; e_strb = 0;
      if (m_q.size() > 0) begin
        e_size = m_q[0].size;
`ifdef STORE_BUFFER_STRB_EN
        e_addr = m_q[0].addr & 32'hFFFF_FFFC;
        case (m_q[0].size)
          2'd0: begin
            e_strb = 4'(1 << m_q[0].addr[1:0]);
            e_data = m_q[0].data[7:0] * 32'h0101_0101;
          end
          2'd1: begin
            e_strb = 4'(3 << m_q[0].addr[1:0]);
            e_data = m_q[0].data[15:0] * 32'h0001_0001;
          end
          default: begin
            e_strb = 4'hF;
            e_data = m_q[0].data;
          end
        endcase
`else
        e_addr = m_q[0].addr;
        e_data = m_q[0].data;
`endif
      end
      chk("full",     32'(full_o),  32'(m_q.size() == DEPTH));
      chk("empty",    32'(empty_o), 32'(m_q.size() == 0));
      chk("valid",    32'(valid_o), 32'(m_q.size() != 0));
      chk("addr",     addr_o,       e_addr);
      chk("data",     data_o,       e_data);
      chk("size",     32'(size_o),  32'(e_size));
      chk("strb",     32'(strb_o),  32'(e_strb));
      chk("overflow", 32'(ovf_o),   32'(m_ovf));
      chk("misalign", 32'(mis_o),   32'(m_mis));
    end
  end

  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] id,
                      input logic [1:0] is, input logic ir);
    v = iv; a = ia; d = id; s = is; rdy = ir;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic ir);
    step(1'b0, 32'h0, 32'h0, 2'd0, ir);
  endtask

  initial begin
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;
    int          w0;

    rstn = 1'b0; v = 0; a = 0; d = 0; s = 0; rdy = 0;
    m_ovf = 0; m_mis = 0;
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    rstn = 1'b1;
    chk_en = 1'b1;
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);

    // Single word store, visible one cycle, drained with ready held high.
    step(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b1);
    chk("single_valid", 32'(valid_o), 32'd1);
    chk("single_addr",  addr_o, 32'h100);
    chk("single_data",  data_o, 32'hDEADBEEF);
`ifdef STORE_BUFFER_STRB_EN
    chk("single_strb",  32'(strb_o), 32'hF);
`endif
    idle(1'b1);
    chk("single_once", 32'(valid_o), 32'd0);

    // Fill to DEPTH with ready low; fifth push is dropped.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h400 + 32'(i * 4), 32'h1000 + 32'(i), 2'd2, 1'b0);
      if (i == 3) chk("fill_full4", 32'(full_o), 32'd1);
    end
    chk("fill_ovf", 32'(ovf_o), 32'd1);
    chk("fill_head", data_o, 32'h1000);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_empty", 32'(empty_o), 32'd1);

    // Stall stability with a byte store at 0x203.
    step(1'b1, 32'h203, 32'hAB, 2'd0, 1'b0);
    h_addr = addr_o; h_data = data_o; h_strb = strb_o;
`ifdef STORE_BUFFER_STRB_EN
    chk("stall_addr", h_addr, 32'h200);
    chk("stall_data", h_data, 32'hABABABAB);
    chk("stall_strb", 32'(h_strb), 32'h8);
`else
    chk("stall_addr", h_addr, 32'h203);
    chk("stall_data", h_data, 32'hAB);
`endif
    idle(1'b0);
    chk("stall_hold_a", addr_o, h_addr);
    chk("stall_hold_d", data_o, h_data);
    idle(1'b0);
    chk("stall_hold_s", 32'(strb_o), 32'(h_strb));
    idle(1'b1);
    chk("stall_popped", 32'(valid_o), 32'd0);

    // Concurrent push and pop at count 2; pointers wrap repeatedly.
    step(1'b1, 32'h500, 32'h50, 2'd2, 1'b0);
    step(1'b1, 32'h504, 32'h51, 2'd2, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h508 + 32'(i * 4), 32'h52 + 32'(i), 2'd2, 1'b1);
    chk("conc_head", data_o, 32'h5A);
    chk("conc_notfull", 32'(full_o), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Misaligned half store.
    step(1'b1, 32'h101, 32'h1234, 2'd1, 1'b0);
`ifdef STORE_BUFFER_STRB_EN
    chk("misal_empty", 32'(empty_o), 32'd1);
    chk("misal_flag",  32'(mis_o),   32'd1);
`else
    chk("misal_addr", addr_o, 32'h101);
    chk("misal_size", 32'(size_o), 32'd1);
`endif
    idle(1'b1);

    // Reset with three entries queued and ready low.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i * 4), 32'h60 + 32'(i), 2'd2, 1'b0);
    rstn = 1'b0;
    idle(1'b0);
    rstn = 1'b1;
    chk("rstmid_empty", 32'(empty_o), 32'd1);
    chk("rstmid_valid", 32'(valid_o), 32'd0);
    chk("rstmid_ovf",   32'(ovf_o),   32'd0);
    chk("rstmid_mis",   32'(mis_o),   32'd0);
    w0 = n_writes;
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("rstmid_nowr", 32'(n_writes - w0), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rstn = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 6, {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 15)),
           $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end
    rstn = 1'b1;

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
